// File: rtl/input_port_interrupt.sv
//------------------------------------------------------------------------------
// Module   : input_port_interrupt
// Brief    : K0/K1 key-port peripheral with edge-triggered, read-to-clear
//            interrupt factor flags on the nibble-wide CPU I/O bus.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module input_port_interrupt (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  input_k0,
  input  logic [3:0]  input_k1,
  input  logic [11:0] bus_addr,
  input  logic        bus_write_en,
  input  logic        bus_read_en,
  input  logic [3:0]  bus_wdata,
  output logic [3:0]  bus_rdata,
  output logic        bus_rdata_sel,
  output logic [3:0]  input_k0_mask,
  output logic [3:0]  input_k1_mask,
  output logic [3:0]  input_relation_k0,
  output logic [1:0]  input_factor
);

  localparam logic [11:0] C_ADDR_K0       = 12'hF40;
  localparam logic [11:0] C_ADDR_REL_K0   = 12'hF41;
  localparam logic [11:0] C_ADDR_K1       = 12'hF42;
  localparam logic [11:0] C_ADDR_MASK_K0  = 12'hF14;
  localparam logic [11:0] C_ADDR_MASK_K1  = 12'hF15;
  localparam logic [11:0] C_ADDR_FACT_K0  = 12'hF04;
  localparam logic [11:0] C_ADDR_FACT_K1  = 12'hF05;

  logic [3:0] relation_q, relation_d;
  logic [3:0] mask0_q, mask0_d;
  logic [3:0] mask1_q, mask1_d;
  logic [1:0] factor_q, factor_d;
  logic [3:0] prev_k0_q;
  logic [3:0] prev_k1_q;

  logic       w_fire_k0;
  logic       w_fire_k1;
  logic       w_clr_k0;
  logic       w_clr_k1;

  // A K0 bit fires when it changed and its new level differs from relation.
  assign w_fire_k0 = |(mask0_q & (prev_k0_q ^ input_k0) & (input_k0 ^ relation_q));
  assign w_fire_k1 = |(mask1_q & prev_k1_q & ~input_k1);
  assign w_clr_k0  = bus_read_en && (bus_addr == C_ADDR_FACT_K0);
  assign w_clr_k1  = bus_read_en && (bus_addr == C_ADDR_FACT_K1);

  always_comb begin
    relation_d = relation_q;
    mask0_d    = mask0_q;
    mask1_d    = mask1_q;
    factor_d   = factor_q;

    if (bus_write_en) begin
      case (bus_addr)
        C_ADDR_REL_K0:  relation_d = bus_wdata;
        C_ADDR_MASK_K0: mask0_d    = bus_wdata;
        C_ADDR_MASK_K1: mask1_d    = bus_wdata;
        default: ;
      endcase
    end

    // Set takes precedence over a coincident read-clear so no event is lost.
    if (w_clr_k0)  factor_d[0] = 1'b0;
    if (w_clr_k1)  factor_d[1] = 1'b0;
    if (w_fire_k0) factor_d[0] = 1'b1;
    if (w_fire_k1) factor_d[1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      relation_q <= 4'hF;
      mask0_q    <= 4'h0;
      mask1_q    <= 4'h0;
      factor_q   <= 2'b00;
      prev_k0_q  <= input_k0;
      prev_k1_q  <= input_k1;
    end else begin
      relation_q <= relation_d;
      mask0_q    <= mask0_d;
      mask1_q    <= mask1_d;
      factor_q   <= factor_d;
      prev_k0_q  <= input_k0;
      prev_k1_q  <= input_k1;
    end
  end

  always_comb begin
    bus_rdata     = 4'h0;
    bus_rdata_sel = 1'b1;
    case (bus_addr)
      C_ADDR_K0:      bus_rdata = input_k0;
      C_ADDR_REL_K0:  bus_rdata = relation_q;
      C_ADDR_K1:      bus_rdata = input_k1;
      C_ADDR_MASK_K0: bus_rdata = mask0_q;
      C_ADDR_MASK_K1: bus_rdata = mask1_q;
      C_ADDR_FACT_K0: bus_rdata = {3'b000, factor_q[0]};
      C_ADDR_FACT_K1: bus_rdata = {3'b000, factor_q[1]};
      default:        bus_rdata_sel = 1'b0;
    endcase
  end

  assign input_k0_mask     = mask0_q;
  assign input_k1_mask     = mask1_q;
  assign input_relation_k0 = relation_q;
  assign input_factor      = factor_q;

endmodule

`default_nettype wire

// File: tb/tb_input_port_interrupt.sv
//------------------------------------------------------------------------------
// Module   : tb_input_port_interrupt
// Brief    : Directed plus randomized bench for input_port_interrupt against a
//            behavioural register/edge model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_input_port_interrupt;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  input_k0;
  logic [3:0]  input_k1;
  logic [11:0] bus_addr;
  logic        bus_write_en;
  logic        bus_read_en;
  logic [3:0]  bus_wdata;
  wire  [3:0]  bus_rdata;
  wire         bus_rdata_sel;
  wire  [3:0]  input_k0_mask;
  wire  [3:0]  input_k1_mask;
  wire  [3:0]  input_relation_k0;
  wire  [1:0]  input_factor;

  input_port_interrupt dut (
    .clk               (clk),
    .reset             (reset),
    .input_k0          (input_k0),
    .input_k1          (input_k1),
    .bus_addr          (bus_addr),
    .bus_write_en      (bus_write_en),
    .bus_read_en       (bus_read_en),
    .bus_wdata         (bus_wdata),
    .bus_rdata         (bus_rdata),
    .bus_rdata_sel     (bus_rdata_sel),
    .input_k0_mask     (input_k0_mask),
    .input_k1_mask     (input_k1_mask),
    .input_relation_k0 (input_relation_k0),
    .input_factor      (input_factor)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: register file plus last sampled pin levels.
  logic [3:0] m_rel, m_m0, m_m1, m_p0, m_p1;
  logic [1:0] m_fac;
  logic [3:0] last_rd;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] model_rd(input logic [11:0] a);
    case (a)
      12'hF40: return {1'b1, input_k0};
      12'hF41: return {1'b1, m_rel};
      12'hF42: return {1'b1, input_k1};
      12'hF14: return {1'b1, m_m0};
      12'hF15: return {1'b1, m_m1};
      12'hF04: return {1'b1, 3'b000, m_fac[0]};
      12'hF05: return {1'b1, 3'b000, m_fac[1]};
      default: return 5'b0;
    endcase
  endfunction

  task automatic model_step();
    bit ev0, ev1;
    if (reset) begin
      m_rel = 4'hF; m_m0 = 4'h0; m_m1 = 4'h0; m_fac = 2'b00;
    end else begin
      ev0 = 0; ev1 = 0;
      for (int n = 0; n < 4; n++) begin
        bit rise, fall;
        rise = (m_p0[n] == 1'b0) && (input_k0[n] == 1'b1);
        fall = (m_p0[n] == 1'b1) && (input_k0[n] == 1'b0);
        if (m_m0[n] && (m_rel[n] ? fall : rise)) ev0 = 1;
        if (m_m1[n] && m_p1[n] == 1'b1 && input_k1[n] == 1'b0) ev1 = 1;
      end
      if (ev0) m_fac[0] = 1'b1;
      else if (bus_read_en && bus_addr == 12'hF04) m_fac[0] = 1'b0;
      if (ev1) m_fac[1] = 1'b1;
      else if (bus_read_en && bus_addr == 12'hF05) m_fac[1] = 1'b0;
      if (bus_write_en) begin
        if (bus_addr == 12'hF41) m_rel = bus_wdata;
        if (bus_addr == 12'hF14) m_m0  = bus_wdata;
        if (bus_addr == 12'hF15) m_m1  = bus_wdata;
      end
    end
    m_p0 = input_k0;
    m_p1 = input_k1;
  endtask

  task automatic cycle(input logic rst, input logic [11:0] a, input logic we, input logic re,
                       input logic [3:0] wd, input logic [3:0] k0v, input logic [3:0] k1v);
    logic [4:0] e;
    reset = rst; bus_addr = a; bus_write_en = we; bus_read_en = re;
    bus_wdata = wd; input_k0 = k0v; input_k1 = k1v;
    #1;
    e = model_rd(a);
    last_rd = bus_rdata;
    chk("rdata", {8'h0, bus_rdata}, {8'h0, e[3:0]});
    chk("rdata_sel", {11'h0, bus_rdata_sel}, {11'h0, e[4]});
    model_step();
    @(posedge clk);
    #1;
    chk("factor", {10'h0, input_factor}, {10'h0, m_fac});
    chk("mask0", {8'h0, input_k0_mask}, {8'h0, m_m0});
    chk("mask1", {8'h0, input_k1_mask}, {8'h0, m_m1});
    chk("relation", {8'h0, input_relation_k0}, {8'h0, m_rel});
  endtask

  task automatic idle(input logic [3:0] k0v, input logic [3:0] k1v);
    cycle(1'b0, 12'h000, 1'b0, 1'b0, 4'h0, k0v, k1v);
  endtask

  task automatic wr(input logic [11:0] a, input logic [3:0] d, input logic [3:0] k0v, input logic [3:0] k1v);
    cycle(1'b0, a, 1'b1, 1'b0, d, k0v, k1v);
  endtask

  task automatic rd(input logic [11:0] a, input logic [3:0] k0v, input logic [3:0] k1v);
    cycle(1'b0, a, 1'b0, 1'b1, 4'h0, k0v, k1v);
  endtask

  localparam logic [11:0] ADDRS [8] = '{12'hF40, 12'hF41, 12'hF42, 12'hF14,
                                         12'hF15, 12'hF04, 12'hF05, 12'hF06};

  initial begin
    logic [3:0] k0, k1;
    m_p0 = 4'h0; m_p1 = 4'h0;
    m_rel = 4'hF; m_m0 = 4'h0; m_m1 = 4'h0; m_fac = 2'b00;

    cycle(1'b1, 12'h000, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    cycle(1'b1, 12'h000, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    chk("rst_relation", {8'h0, input_relation_k0}, 12'hF);
    chk("rst_mask0", {8'h0, input_k0_mask}, 12'h0);
    chk("rst_mask1", {8'h0, input_k1_mask}, 12'h0);
    chk("rst_factor", {10'h0, input_factor}, 12'h0);

    // Pin reads are combinational.
    rd(12'hF40, 4'h7, 4'h9);
    chk("pin_k0", {8'h0, last_rd}, 12'h7);
    rd(12'hF42, 4'h7, 4'h9);
    chk("pin_k1", {8'h0, last_rd}, 12'h9);

    wr(12'hF41, 4'h5, 4'h7, 4'h9);
    wr(12'hF14, 4'hA, 4'h7, 4'h9);
    wr(12'hF15, 4'h3, 4'h7, 4'h9);
    chk("wr_relation", {8'h0, input_relation_k0}, 12'h5);
    chk("wr_mask0", {8'h0, input_k0_mask}, 12'hA);
    chk("wr_mask1", {8'h0, input_k1_mask}, 12'h3);
    rd(12'hF41, 4'h7, 4'h9); chk("rb_relation", {8'h0, last_rd}, 12'h5);
    rd(12'hF14, 4'h7, 4'h9); chk("rb_mask0", {8'h0, last_rd}, 12'hA);
    rd(12'hF15, 4'h7, 4'h9); chk("rb_mask1", {8'h0, last_rd}, 12'h3);

    // Mixed polarity: bit1 falling, others rising.
    wr(12'hF14, 4'hF, 4'h0, 4'h0);
    wr(12'hF41, 4'h2, 4'h0, 4'h0);
    idle(4'h0, 4'h0);
    rd(12'hF04, 4'h0, 4'h0);
    rd(12'hF05, 4'h0, 4'h0);
    for (int n = 0; n < 4; n++) begin
      k0 = 4'h1 << n;
      idle(k0, 4'h0);
      chk("k0_rise", {11'h0, input_factor[0]}, (n != 1) ? 12'h1 : 12'h0);
      rd(12'hF04, k0, 4'h0);
      chk("k0_clear", {11'h0, input_factor[0]}, 12'h0);
      idle(4'h0, 4'h0);
      chk("k0_fall", {11'h0, input_factor[0]}, (n == 1) ? 12'h1 : 12'h0);
      rd(12'hF04, 4'h0, 4'h0);
    end

    // Reset relation (all falling), only bit 2 unmasked.
    cycle(1'b1, 12'h000, 1'b0, 1'b0, 4'h0, 4'hF, 4'h0);
    wr(12'hF14, 4'h4, 4'hF, 4'h0);
    for (int n = 0; n < 4; n++) begin
      k0 = 4'hF & ~(4'h1 << n);
      idle(k0, 4'h0);
      chk("k0_mask_fall", {11'h0, input_factor[0]}, (n == 2) ? 12'h1 : 12'h0);
      rd(12'hF04, k0, 4'h0);
      idle(4'hF, 4'h0);
      chk("k0_mask_rise", {11'h0, input_factor[0]}, 12'h0);
    end

    // K1 falling edge, read-clear, rising edge ignored.
    wr(12'hF15, 4'hF, 4'hF, 4'h4);
    idle(4'hF, 4'h4);
    idle(4'hF, 4'h0);
    chk("k1_fall", {10'h0, input_factor}, 12'h2);
    rd(12'hF05, 4'hF, 4'h0);
    chk("k1_rd", {8'h0, last_rd}, 12'h1);
    chk("k1_cleared", {10'h0, input_factor}, 12'h0);
    idle(4'hF, 4'h4);
    chk("k1_rise", {10'h0, input_factor}, 12'h0);

    // K0 edge, then set colliding with read-clear.
    wr(12'hF14, 4'hC, 4'h8, 4'h4);
    rd(12'hF04, 4'h8, 4'h4);
    idle(4'h0, 4'h4);
    chk("k0_fall8", {10'h0, input_factor}, 12'h1);
    idle(4'h4, 4'h4);
    rd(12'hF04, 4'h0, 4'h4);
    chk("set_beats_clear", {10'h0, input_factor}, 12'h1);
    rd(12'hF04, 4'h0, 4'h4);
    chk("clear_after", {10'h0, input_factor}, 12'h0);

    // Randomized traffic against the model.
    k0 = 4'h0; k1 = 4'h0;
    for (int i = 0; i < 1500; i++) begin
      logic [11:0] a;
      if ($urandom_range(0, 3) == 0) k0 = k0 ^ (4'h1 << $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) k1 = k1 ^ (4'h1 << $urandom_range(0, 3));
      a = ($urandom_range(0, 9) == 0) ? 12'($urandom) : ADDRS[$urandom_range(0, 7)];
      cycle($urandom_range(0, 99) == 0, a, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, 4'($urandom), k0, k1);
    end

    bus_write_en = 1'b0;
    bus_read_en  = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
